seq_detect_sched: RTL

//  Time-shares one 10110 Mealy sequence-detector step function among NCH serial bit channels.
//  - One bit accepted per cycle, chosen by a round-robin arbiter.
//  - Each channel's detector state is saved and restored, so streams never mix.
//  - Overlapping matches are counted per channel.

---
 rtl/seq_sched_pkg.sv | 39 +++
 rtl/seq_detect_sched_rr_arbiter.sv | 33 +++
 rtl/seq_detect_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and the 10110 Mealy step function for the time-shared detector.
// All channels use this one step function.
package seq_sched_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_t;

    localparam det_state_t DET_RESET = S0;

    typedef struct packed {
        det_state_t next_state;
        logic       match;
    } det_step_t;

    function automatic det_step_t det_step(input det_state_t state, input logic b);
        det_step_t r;
        r.next_state = S0;
        r.match      = 1'b0;
        case (state)
            S0: r.next_state = b ? S1 : S0;
            S1: r.next_state = b ? S1 : S2;
            S2: r.next_state = b ? S3 : S0;
            S3: r.next_state = b ? S4 : S2;
            S4: begin
                // On a match, fall back to S2 so the trailing "10" can start the next match.
                r.next_state = b ? S1 : S2;
                r.match      = ~b;
            end
            default: r.next_state = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible channel at or after ptr.
module rr_arbiter #(
    parameter int unsigned NCH = 4,
    localparam int unsigned IW = $clog2(NCH)
) (
    input  logic [NCH-1:0] elig_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  gnt_idx_o,
    output logic           any_gnt_o
);

    logic [IW:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        cand      = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand >= (IW+1)'(NCH)) begin
                cand = cand - (IW+1)'(NCH);
            end
            if (!any_gnt_o && elig_i[cand[IW-1:0]]) begin
                any_gnt_o               = 1'b1;
                gnt_idx_o               = cand[IW-1:0];
                gnt_o[cand[IW-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-shared 10110 detector: one arbitrated bit per cycle, per-channel saved context
// and saturating match counters.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8,
    localparam int unsigned IW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    j,
    input  logic [NCH-1:0]    clr,
    output logic [NCH-1:0]    gnt,
    output logic              w,
    output logic [IW-1:0]     w_ch,
    output logic [NCH*CW-1:0] cnt_flat
);

    det_state_t      ctx_q [NCH];
    det_state_t      ctx_d [NCH];
    logic [CW-1:0]   cnt_q [NCH];
    logic [CW-1:0]   cnt_d [NCH];
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            w_q, w_d;
    logic [IW-1:0]   w_ch_q, w_ch_d;

    logic [NCH-1:0]  arb_gnt;
    logic [IW-1:0]   gnt_idx;
    logic            any_gnt;
    det_step_t       step;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .elig_i    (req & ~clr),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    assign gnt = rst ? '0 : arb_gnt;

    always_comb begin
        ctx_d  = ctx_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        w_d    = 1'b0;
        w_ch_d = w_ch_q;
        step   = det_step(ctx_q[gnt_idx], j[gnt_idx]);

        for (int i = 0; i < int'(NCH); i++) begin
            if (clr[i]) begin
                ctx_d[i] = DET_RESET;
                cnt_d[i] = '0;
            end
        end

        // A granted channel is never being cleared, so these writes cannot collide.
        if (any_gnt) begin
            ctx_d[gnt_idx] = step.next_state;
            ptr_d = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
            if (step.match) begin
                w_d    = 1'b1;
                w_ch_d = gnt_idx;
                if (cnt_q[gnt_idx] != '1) begin
                    cnt_d[gnt_idx] = cnt_q[gnt_idx] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) begin
                ctx_q[i] <= DET_RESET;
                cnt_q[i] <= '0;
            end
            ptr_q  <= '0;
            w_q    <= 1'b0;
            w_ch_q <= '0;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                ctx_q[i] <= ctx_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q  <= ptr_d;
            w_q    <= w_d;
            w_ch_q <= w_ch_d;
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            cnt_flat[i*CW +: CW] = cnt_q[i];
        end
    end

    assign w    = w_q;
    assign w_ch = w_ch_q;

endmodule
